alu: RTL and testbench
======================

Name: alu

Overview:
Registered 16-bit ALU with arithmetic, logic and shift/rotate groups, selected by a 3-bit mode and a 3-bit opcode.
Produces a 32-bit result plus zero and compare flags on both operands.
Sits in the CPU datapath between the register file read ports and the writeback mux.
All outputs are registered, giving one cycle of latency.

Parameters:
None. Operand width is fixed at 16 bits and result width at 32 bits.

Ports:
clk     input   1   rising-edge clock
rst_n   input   1   reset, synchronous, active-low
a       input   16  operand A
b       input   16  operand B
opcode  input   3   operation select within the mode group
mode    input   3   group select: 0 arithmetic, 1 logic, 2 shift/rotate, 3-7 reserved
outALU  output  32  registered result
za      output  1   registered: a == 0
zb      output  1   registered: b == 0
eq      output  1   registered: a == b (unsigned)
gt      output  1   registered: a > b (unsigned)
lt      output  1   registered: a < b (unsigned)

Behaviour:
- One clock; reset is synchronous and active-low. On a rising clk edge with rst_n=0, all outputs clear: outALU=0 and za=zb=eq=gt=lt=0. Reset overrides any concurrent input.
- Otherwise, on every rising edge, outputs are registered from the current a/b/opcode/mode. Latency is 1 cycle. No handshake; a new operation is accepted every cycle.
- All operands are treated as unsigned unless an operation states otherwise.
- Mode 0, arithmetic:
  - 000: a+b, zero-extended; carry lands in bit 16.
  - 001: a-b, computed in 32-bit two's complement (5-7 = 32'hFFFF_FFFE).
  - 010: a*b, full 32-bit product.
  - 011: a/b, quotient. If b=0, result is 32'hFFFF_FFFF.
  - 100: a%b. If b=0, result is {16'h0,a}.
  - 101: a+1, zero-extended (16'hFFFF gives 32'h0001_0000).
  - 110: a-1, in 32-bit two's complement (0 gives 32'hFFFF_FFFF).
  - 111: pass a, zero-extended.
- Mode 1, logic: bitwise operation on 16 bits, with the upper 16 bits of the result forced to 0.
  - 000: AND
  - 001: OR
  - 010: XOR
  - 011: NAND
  - 100: NOR
  - 101: XNOR
  - 110: ~a
  - 111: ~b
- Mode 2, shift/rotate: the shift amount is b[3:0]. The 16-bit result is zero-extended to 32 bits.
  - 000: logical shift left
  - 001: logical shift right
  - 010: arithmetic shift right (a[15] replicated)
  - 011: rotate left
  - 100: rotate right
  - 101: a shifted left 1
  - 110: a shifted right 1
  - 111: byte swap {a[7:0],a[15:8]}
  - A shift amount of 0 returns a unchanged.
- Modes 3-7 are reserved: outALU=0.
- Flags depend only on a and b and are independent of mode/opcode. They update every cycle, including in reserved modes.
- Exactly one of eq/gt/lt is 1 after reset is released.
- Inputs must be stable only at the clock edge. Glitches between edges have no effect.
- Divide and modulo are combinational single-cycle operations; no multi-cycle divider.

Test Plan:
1. Reset: rst_n=0 with a=5, b=7, mode=0, opcode=000, one edge -> outALU=0, all flags 0. Release rst_n, one edge -> outALU=32'h0000_000C, lt=1, eq=gt=za=zb=0.
2. Arithmetic sweep with a=16'h0005, b=16'h0007, mode=0, opcode 000..111 on consecutive cycles -> results appear one cycle later: 0x0C, 0xFFFF_FFFE, 0x23, 0x0, 0x5, 0x6, 0x4, 0x5.
3. Logic sweep with a=5, b=7, mode=1, opcode 000..111 -> 0x5, 0x7, 0x2, 0xFFFA, 0xFFF8, 0xFFFD, 0xFFFA, 0xFFF8; upper 16 bits are 0 in every case.
4. Shift/rotate with a=16'h8001, b=16'h0004, mode=2:
   - opcode 000 -> 0x0010
   - opcode 001 -> 0x0800
   - opcode 010 -> 0xF800
   - opcode 011 -> 0x0018
   - opcode 100 -> 0x1800
   - opcode 111 -> 0x0180
5. Edge cases:
   - a=16'hFFFF, b=16'hFFFF, mode=0, opcode 000 -> 0x0001_FFFE.
   - Same operands, opcode 010 -> 0xFFFE_0001; eq=1.
   - b=0, opcode 011 -> 0xFFFF_FFFF.
   - b=0, opcode 100 -> {16'h0,a}.
6. Flags and reserved mode:
   - a=0, b=7 -> za=1, lt=1.
   - Then b=0 -> zb=1, eq=1.
   - mode=3, any opcode -> outALU=0 while flags keep tracking a and b.

Source files
------------

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Registered 16-bit ALU (arithmetic, logic, shift/rotate)
//                with a 32-bit result and unsigned operand compare flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  opcode,
    input  logic [2:0]  mode,
    output logic [31:0] outALU,
    output logic        za,
    output logic        zb,
    output logic        eq,
    output logic        gt,
    output logic        lt
);

    localparam logic [2:0] c_MODE_ARITH = 3'd0;
    localparam logic [2:0] c_MODE_LOGIC = 3'd1;
    localparam logic [2:0] c_MODE_SHIFT = 3'd2;

    logic [16:0] w_sum;
    logic [16:0] w_inc;
    logic [31:0] w_diff;
    logic [31:0] w_dec;
    logic [31:0] w_prod;
    logic [15:0] w_quot;
    logic [15:0] w_rem;
    logic        w_b_zero;

    logic [3:0]  w_amt;
    logic [4:0]  w_amt_inv;
    logic [15:0] w_sll;
    logic [15:0] w_srl;
    logic [15:0] w_sra;
    logic [15:0] w_rol;
    logic [15:0] w_ror;

    logic [15:0] w_logic;
    logic [15:0] w_shift;
    logic [31:0] w_arith;
    logic [31:0] w_result;

    // Arithmetic datapath: widen before the operator so carries/borrows survive
    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_inc    = {1'b0, a} + 17'd1;
    assign w_diff   = {16'h0000, a} - {16'h0000, b};
    assign w_dec    = {16'h0000, a} - 32'd1;
    assign w_prod   = {16'h0000, a} * {16'h0000, b};
    assign w_b_zero = (b == 16'h0000);
    assign w_quot   = w_b_zero ? 16'h0000 : (a / b);
    assign w_rem    = w_b_zero ? 16'h0000 : (a % b);

    // A right shift by 16 yields zero, so rotate by 0 collapses to a itself
    assign w_amt     = b[3:0];
    assign w_amt_inv = 5'd16 - {1'b0, w_amt};
    assign w_sll     = a << w_amt;
    assign w_srl     = a >> w_amt;
    assign w_sra     = $signed(a) >>> w_amt;
    assign w_rol     = (a << w_amt) | (a >> w_amt_inv);
    assign w_ror     = (a >> w_amt) | (a << w_amt_inv);

    always_comb begin
        w_arith = 32'h0000_0000;
        case (opcode)
            3'd0: w_arith = {15'h0000, w_sum};
            3'd1: w_arith = w_diff;
            3'd2: w_arith = w_prod;
            3'd3: w_arith = w_b_zero ? 32'hFFFF_FFFF : {16'h0000, w_quot};
            3'd4: w_arith = w_b_zero ? {16'h0000, a} : {16'h0000, w_rem};
            3'd5: w_arith = {15'h0000, w_inc};
            3'd6: w_arith = w_dec;
            3'd7: w_arith = {16'h0000, a};
            default: w_arith = 32'h0000_0000;
        endcase
    end

    always_comb begin
        w_logic = 16'h0000;
        case (opcode)
            3'd0: w_logic = a & b;
            3'd1: w_logic = a | b;
            3'd2: w_logic = a ^ b;
            3'd3: w_logic = ~(a & b);
            3'd4: w_logic = ~(a | b);
            3'd5: w_logic = ~(a ^ b);
            3'd6: w_logic = ~a;
            3'd7: w_logic = ~b;
            default: w_logic = 16'h0000;
        endcase
    end

    always_comb begin
        w_shift = 16'h0000;
        case (opcode)
            3'd0: w_shift = w_sll;
            3'd1: w_shift = w_srl;
            3'd2: w_shift = w_sra;
            3'd3: w_shift = w_rol;
            3'd4: w_shift = w_ror;
            3'd5: w_shift = {a[14:0], 1'b0};
            3'd6: w_shift = {1'b0, a[15:1]};
            3'd7: w_shift = {a[7:0], a[15:8]};
            default: w_shift = 16'h0000;
        endcase
    end

    always_comb begin
        w_result = 32'h0000_0000;
        case (mode)
            c_MODE_ARITH: w_result = w_arith;
            c_MODE_LOGIC: w_result = {16'h0000, w_logic};
            c_MODE_SHIFT: w_result = {16'h0000, w_shift};
            default:      w_result = 32'h0000_0000;
        endcase
    end

    // Flags track the operands every cycle regardless of mode/opcode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outALU <= 32'h0000_0000;
            za     <= 1'b0;
            zb     <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
        end else begin
            outALU <= w_result;
            za     <= (a == 16'h0000);
            zb     <= w_b_zero;
            eq     <= (a == b);
            gt     <= (a > b);
            lt     <= (a < b);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu
//  Description : Directed self-checking bench for the registered ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  opcode;
    logic [2:0]  mode;
    logic [31:0] outALU;
    logic        za, zb, eq, gt, lt;

    int checks;
    int errors;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .mode   (mode),
        .outALU (outALU),
        .za     (za),
        .zb     (zb),
        .eq     (eq),
        .gt     (gt),
        .lt     (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags packed as {za,zb,eq,gt,lt}
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a = 16'd5; b = 16'd7; mode = 3'd0; opcode = 3'd0;
        step();
        checks++;
        if (outALU !== 32'h0) begin
            errors++; $display("FAIL reset_out actual=%h required=%h", outALU, 32'h0);
        end
        checks++;
        if ({za, zb, eq, gt, lt} !== 5'b00000) begin
            errors++; $display("FAIL reset_flags actual=%b required=%b", {za, zb, eq, gt, lt}, 5'b00000);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (outALU !== 32'h0000_000C) begin
            errors++; $display("FAIL release_out actual=%h required=%h", outALU, 32'h0000_000C);
        end
        checks++;
        if ({za, zb, eq, gt, lt} !== 5'b00001) begin
            errors++; $display("FAIL release_flags actual=%b required=%b", {za, zb, eq, gt, lt}, 5'b00001);
        end
        // Reset must win over live inputs mid-run
        rst_n = 1'b0; a = 16'h1234; b = 16'h0001;
        step();
        checks++;
        if (outALU !== 32'h0 || {za, zb, eq, gt, lt} !== 5'b00000) begin
            errors++; $display("FAIL reset_override actual=%h/%b required=%h/%b",
                               outALU, {za, zb, eq, gt, lt}, 32'h0, 5'b00000);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [31:0] exp_tab [8];
        exp_tab = '{32'h0000_000C, 32'hFFFF_FFFE, 32'h0000_0023, 32'h0000_0000,
                    32'h0000_0005, 32'h0000_0006, 32'h0000_0004, 32'h0000_0005};
        a = 16'd5; b = 16'd7; mode = 3'd0;
        for (int i = 0; i < 8; i++) begin
            opcode = 3'(i);
            step();
            checks++;
            if (outALU !== exp_tab[i]) begin
                errors++; $display("FAIL arith_op%0d actual=%h required=%h", i, outALU, exp_tab[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [31:0] exp_tab [8];
        exp_tab = '{32'h0000_0005, 32'h0000_0007, 32'h0000_0002, 32'h0000_FFFA,
                    32'h0000_FFF8, 32'h0000_FFFD, 32'h0000_FFFA, 32'h0000_FFF8};
        a = 16'd5; b = 16'd7; mode = 3'd1;
        for (int i = 0; i < 8; i++) begin
            opcode = 3'(i);
            step();
            checks++;
            if (outALU !== exp_tab[i]) begin
                errors++; $display("FAIL logic_op%0d actual=%h required=%h", i, outALU, exp_tab[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [31:0] exp_tab [8];
        exp_tab = '{32'h0000_0010, 32'h0000_0800, 32'h0000_F800, 32'h0000_0018,
                    32'h0000_1800, 32'h0000_0002, 32'h0000_4000, 32'h0000_0180};
        a = 16'h8001; b = 16'h0004; mode = 3'd2;
        for (int i = 0; i < 8; i++) begin
            opcode = 3'(i);
            step();
            checks++;
            if (outALU !== exp_tab[i]) begin
                errors++; $display("FAIL shift_op%0d actual=%h required=%h", i, outALU, exp_tab[i]);
            end
        end
        // Shift amount 0 must leave a untouched for every shift/rotate
        a = 16'hB3C5; b = 16'hFFF0;
        for (int i = 0; i < 5; i++) begin
            opcode = 3'(i);
            step();
            checks++;
            if (outALU !== 32'h0000_B3C5) begin
                errors++; $display("FAIL shift0_op%0d actual=%h required=%h", i, outALU, 32'h0000_B3C5);
            end
        end
        // Amount 15 with sign bit set
        a = 16'h8000; b = 16'h000F; opcode = 3'd2;
        step();
        checks++;
        if (outALU !== 32'h0000_FFFF) begin
            errors++; $display("FAIL sra15 actual=%h required=%h", outALU, 32'h0000_FFFF);
        end
        a = 16'h0003; opcode = 3'd4;
        step();
        checks++;
        if (outALU !== 32'h0000_0007 - 32'h1) begin
            errors++; $display("FAIL ror15 actual=%h required=%h", outALU, 32'h0000_0006);
        end
    endtask

    task automatic test_edge();
        a = 16'hFFFF; b = 16'hFFFF; mode = 3'd0; opcode = 3'd0;
        step();
        checks++;
        if (outALU !== 32'h0001_FFFE) begin
            errors++; $display("FAIL add_carry actual=%h required=%h", outALU, 32'h0001_FFFE);
        end
        opcode = 3'd2;
        step();
        checks++;
        if (outALU !== 32'hFFFE_0001 || eq !== 1'b1) begin
            errors++; $display("FAIL mul_max actual=%h/eq=%b required=%h/eq=1", outALU, eq, 32'hFFFE_0001);
        end
        opcode = 3'd5;
        step();
        checks++;
        if (outALU !== 32'h0001_0000) begin
            errors++; $display("FAIL inc_wrap actual=%h required=%h", outALU, 32'h0001_0000);
        end
        b = 16'h0000; opcode = 3'd3;
        step();
        checks++;
        if (outALU !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_by0 actual=%h required=%h", outALU, 32'hFFFF_FFFF);
        end
        a = 16'h1234; opcode = 3'd4;
        step();
        checks++;
        if (outALU !== 32'h0000_1234) begin
            errors++; $display("FAIL mod_by0 actual=%h required=%h", outALU, 32'h0000_1234);
        end
        a = 16'd1000; b = 16'd7; opcode = 3'd3;
        step();
        checks++;
        if (outALU !== 32'd142) begin
            errors++; $display("FAIL div_norm actual=%h required=%h", outALU, 32'd142);
        end
        opcode = 3'd4;
        step();
        checks++;
        if (outALU !== 32'd6) begin
            errors++; $display("FAIL mod_norm actual=%h required=%h", outALU, 32'd6);
        end
        a = 16'h0000; opcode = 3'd6;
        step();
        checks++;
        if (outALU !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL dec_zero actual=%h required=%h", outALU, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_flags();
        a = 16'h0000; b = 16'h0007; mode = 3'd0; opcode = 3'd7;
        step();
        checks++;
        if ({za, zb, eq, gt, lt} !== 5'b10001) begin
            errors++; $display("FAIL flags_za actual=%b required=%b", {za, zb, eq, gt, lt}, 5'b10001);
        end
        b = 16'h0000;
        step();
        checks++;
        if ({za, zb, eq, gt, lt} !== 5'b11100) begin
            errors++; $display("FAIL flags_zero actual=%b required=%b", {za, zb, eq, gt, lt}, 5'b11100);
        end
        // Reserved modes: result zero, flags still live
        a = 16'h0009; b = 16'h0003;
        for (int m = 3; m < 8; m++) begin
            mode = 3'(m); opcode = 3'(m - 1);
            step();
            checks++;
            if (outALU !== 32'h0 || {za, zb, eq, gt, lt} !== 5'b00010) begin
                errors++; $display("FAIL reserved_mode%0d actual=%h/%b required=%h/%b",
                                   m, outALU, {za, zb, eq, gt, lt}, 32'h0, 5'b00010);
            end
        end
        a = 16'h0002; b = 16'hFFFF; mode = 3'd5;
        step();
        checks++;
        if (outALU !== 32'h0 || {za, zb, eq, gt, lt} !== 5'b00001) begin
            errors++; $display("FAIL reserved_lt actual=%h/%b required=%h/%b",
                               outALU, {za, zb, eq, gt, lt}, 32'h0, 5'b00001);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = 16'h0;
        b      = 16'h0;
        opcode = 3'd0;
        mode   = 3'd0;
        #2;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_edge();
        test_flags();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
